// File: rtl/fix_seq_tracker.sv
// rtl/fix_seq_tracker.sv - FIX session sequence-number tracker with gap detection and resend request
module fix_seq_tracker #(
  parameter int SEQ_W    = 16,
  parameter int INIT_SEQ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid_i,
  input  logic [SEQ_W-1:0] rx_seq_i,
  input  logic             rx_poss_dup_i,
  input  logic             rx_ignore_i,
  input  logic             seq_reset_i,
  input  logic [SEQ_W-1:0] seq_reset_new_i,
  input  logic             send_i,
  input  logic             resend_ack_i,
  output logic [SEQ_W-1:0] expected_seq_o,
  output logic [SEQ_W-1:0] outgoing_seq_o,
  output logic             rx_accept_o,
  output logic             rx_dup_o,
  output logic             rx_gap_o,
  output logic             rx_low_o,
  output logic             err_low_o,
  output logic             resend_req_o,
  output logic [SEQ_W-1:0] resend_begin_o,
  output logic [SEQ_W-1:0] resend_end_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {SYNC = 2'd0, REQ = 2'd1, RECOVER = 2'd2} state_t;

  localparam logic [SEQ_W-1:0] MAX_SEQ  = '1;
  localparam logic [SEQ_W-1:0] ONE      = SEQ_W'(1);
  localparam logic [SEQ_W-1:0] INIT_VAL = SEQ_W'(INIT_SEQ);

  // Sequence numbers skip zero on wrap.
  function automatic logic [SEQ_W-1:0] seq_inc(input logic [SEQ_W-1:0] s);
    return (s == MAX_SEQ) ? ONE : s + ONE;
  endfunction

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] exp_seq_q, exp_seq_d;
  logic [SEQ_W-1:0] out_seq_q, out_seq_d;
  logic [SEQ_W-1:0] begin_q, begin_d;
  logic [SEQ_W-1:0] end_q, end_d;
  logic             acc_q, acc_d;
  logic             dup_q, dup_d;
  logic             gap_q, gap_d;
  logic             low_q, low_d;
  logic             err_q, err_d;
  logic             req_q, req_d;

  always_comb begin
    state_d   = state_q;
    exp_seq_d = exp_seq_q;
    out_seq_d = out_seq_q;
    begin_d   = begin_q;
    end_d     = end_q;
    req_d     = req_q;
    acc_d     = 1'b0;
    dup_d     = 1'b0;
    gap_d     = 1'b0;
    low_d     = 1'b0;

    if (send_i) out_seq_d = seq_inc(out_seq_q);

    // Ack moves REQ to RECOVER; a same-cycle recovery exit below overrides it.
    if (state_q == REQ && resend_ack_i) begin
      state_d = RECOVER;
      req_d   = 1'b0;
    end

    if (seq_reset_i) begin
      if (seq_reset_new_i >= exp_seq_q) begin
        exp_seq_d = seq_reset_new_i;
        if (state_q != SYNC && seq_reset_new_i > end_q) begin
          state_d = SYNC;
          req_d   = 1'b0;
        end
      end else begin
        low_d = 1'b1;
      end
    end else if (rx_valid_i && !rx_ignore_i) begin
      if (rx_seq_i == exp_seq_q) begin
        acc_d     = 1'b1;
        exp_seq_d = seq_inc(exp_seq_q);
        if (state_q != SYNC && exp_seq_q >= end_q) begin
          state_d = SYNC;
          req_d   = 1'b0;
        end
      end else if (rx_seq_i > exp_seq_q) begin
        gap_d = 1'b1;
        if (state_q == SYNC) begin
          begin_d = exp_seq_q;
          end_d   = rx_seq_i - ONE;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end else if (rx_poss_dup_i) begin
        dup_d = 1'b1;
      end else begin
        low_d = 1'b1;
      end
    end

    err_d = err_q | low_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SYNC;
      exp_seq_q <= INIT_VAL;
      out_seq_q <= INIT_VAL;
      begin_q   <= '0;
      end_q     <= '0;
      req_q     <= 1'b0;
      acc_q     <= 1'b0;
      dup_q     <= 1'b0;
      gap_q     <= 1'b0;
      low_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_seq_q <= exp_seq_d;
      out_seq_q <= out_seq_d;
      begin_q   <= begin_d;
      end_q     <= end_d;
      req_q     <= req_d;
      acc_q     <= acc_d;
      dup_q     <= dup_d;
      gap_q     <= gap_d;
      low_q     <= low_d;
      err_q     <= err_d;
    end
  end

  assign expected_seq_o = exp_seq_q;
  assign outgoing_seq_o = out_seq_q;
  assign rx_accept_o    = acc_q;
  assign rx_dup_o       = dup_q;
  assign rx_gap_o       = gap_q;
  assign rx_low_o       = low_q;
  assign err_low_o      = err_q;
  assign resend_req_o   = req_q;
  assign resend_begin_o = begin_q;
  assign resend_end_o   = end_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_fix_seq_tracker.sv
// tb/tb_fix_seq_tracker.sv - self-checking bench for fix_seq_tracker (SEQ_W=4 to exercise wrap)
module tb_fix_seq_tracker;

  localparam int W   = 4;
  localparam int MOD = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rx_valid_i = 1'b0, rx_poss_dup_i = 1'b0, rx_ignore_i = 1'b0;
  logic         seq_reset_i = 1'b0, send_i = 1'b0, resend_ack_i = 1'b0;
  logic [W-1:0] rx_seq_i = '0, seq_reset_new_i = '0;
  logic [W-1:0] expected_seq_o, outgoing_seq_o, resend_begin_o, resend_end_o;
  logic         rx_accept_o, rx_dup_o, rx_gap_o, rx_low_o, err_low_o, resend_req_o;
  logic [1:0]   state_o;

  int checks = 0;
  int failures = 0;

  // Reference model state (plain integers).
  int m_exp, m_out, m_state, m_begin, m_end;
  int m_req, m_err, m_acc, m_dup, m_gap, m_low;

  fix_seq_tracker #(.SEQ_W(W), .INIT_SEQ(1)) dut (
    .clk(clk), .rst(rst),
    .rx_valid_i(rx_valid_i), .rx_seq_i(rx_seq_i), .rx_poss_dup_i(rx_poss_dup_i),
    .rx_ignore_i(rx_ignore_i), .seq_reset_i(seq_reset_i), .seq_reset_new_i(seq_reset_new_i),
    .send_i(send_i), .resend_ack_i(resend_ack_i),
    .expected_seq_o(expected_seq_o), .outgoing_seq_o(outgoing_seq_o),
    .rx_accept_o(rx_accept_o), .rx_dup_o(rx_dup_o), .rx_gap_o(rx_gap_o), .rx_low_o(rx_low_o),
    .err_low_o(err_low_o), .resend_req_o(resend_req_o),
    .resend_begin_o(resend_begin_o), .resend_end_o(resend_end_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic int nxt(input int x);
    return (x % MOD) + 1;
  endfunction

  function automatic void model_step(input bit r, v, input int seq, input bit pd, ig, sr,
                                     input int nsq, input bit snd, ack);
    m_acc = 0; m_dup = 0; m_gap = 0; m_low = 0;
    if (r) begin
      m_exp = 1; m_out = 1; m_state = 0; m_begin = 0; m_end = 0; m_req = 0; m_err = 0;
      return;
    end
    if (snd) m_out = nxt(m_out);
    if (m_state == 1 && ack) begin m_state = 2; m_req = 0; end
    if (sr) begin
      if (nsq < m_exp) m_low = 1;
      else begin
        m_exp = nsq;
        if (m_state != 0 && nsq > m_end) begin m_state = 0; m_req = 0; end
      end
    end else if (v && !ig) begin
      if (seq == m_exp) begin
        m_acc = 1;
        if (m_state != 0 && seq >= m_end) begin m_state = 0; m_req = 0; end
        m_exp = nxt(m_exp);
      end else if (seq > m_exp) begin
        m_gap = 1;
        if (m_state == 0) begin
          m_begin = m_exp; m_end = seq - 1; m_req = 1; m_state = 1;
        end
      end else if (pd) m_dup = 1;
      else m_low = 1;
    end
    if (m_low) m_err = 1;
  endfunction

  // Drive one cycle, advance the model, leave outputs settled #1 after the edge.
  task automatic tick(input bit r, v, input int seq, input bit pd, ig, sr,
                      input int nsq, input bit snd, ack);
    rst = r; rx_valid_i = v; rx_seq_i = W'(seq); rx_poss_dup_i = pd; rx_ignore_i = ig;
    seq_reset_i = sr; seq_reset_new_i = W'(nsq); send_i = snd; resend_ack_i = ack;
    @(posedge clk);
    model_step(r, v, seq, pd, ig, sr, nsq, snd, ack);
    #1;
    rst = 0; rx_valid_i = 0; rx_poss_dup_i = 0; rx_ignore_i = 0;
    seq_reset_i = 0; send_i = 0; resend_ack_i = 0;
  endtask

  task automatic rx(input int seq, input bit pd);
    tick(0, 1, seq, pd, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    tick(1, 1, 9, 0, 0, 1, 12, 1, 1);
    checks++; if (expected_seq_o !== 4'd1) begin failures++; $display("FAIL reset_exp got=%0d want=1", expected_seq_o); end
    checks++; if (outgoing_seq_o !== 4'd1) begin failures++; $display("FAIL reset_out got=%0d want=1", outgoing_seq_o); end
    checks++; if ({state_o, resend_req_o, err_low_o, rx_accept_o, rx_dup_o, rx_gap_o, rx_low_o} !== 8'd0)
      begin failures++; $display("FAIL reset_flags got=%b want=0", {state_o, resend_req_o, err_low_o, rx_accept_o, rx_dup_o, rx_gap_o, rx_low_o}); end
    checks++; if ({resend_begin_o, resend_end_o} !== 8'd0) begin failures++; $display("FAIL reset_range got=%h want=0", {resend_begin_o, resend_end_o}); end
  endtask

  task automatic test_in_order;
    int acc = 0;
    for (int s = 1; s <= 3; s++) begin rx(s, 0); acc += int'(rx_accept_o); end
    checks++; if (acc !== 3) begin failures++; $display("FAIL inorder_accepts got=%0d want=3", acc); end
    checks++; if (expected_seq_o !== 4'd4 || state_o !== 2'd0)
      begin failures++; $display("FAIL inorder_end got exp=%0d st=%0d want exp=4 st=0", expected_seq_o, state_o); end
  endtask

  task automatic test_gap_recovery;
    rx(7, 0);
    checks++; if ({rx_gap_o, resend_req_o, state_o} !== 4'b1101 || resend_begin_o !== 4'd4 || resend_end_o !== 4'd6)
      begin failures++; $display("FAIL gap_open got gap=%b req=%b st=%0d b=%0d e=%0d want 1 1 1 4 6", rx_gap_o, resend_req_o, state_o, resend_begin_o, resend_end_o); end
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (state_o !== 2'd2 || resend_req_o !== 1'b0)
      begin failures++; $display("FAIL gap_ack got st=%0d req=%b want 2 0", state_o, resend_req_o); end
    rx(4, 0); rx(5, 0);
    checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL gap_mid got st=%0d want 2", state_o); end
    rx(6, 0);
    checks++; if (rx_accept_o !== 1'b1 || state_o !== 2'd0 || expected_seq_o !== 4'd7)
      begin failures++; $display("FAIL gap_done got acc=%b st=%0d exp=%0d want 1 0 7", rx_accept_o, state_o, expected_seq_o); end
  endtask

  task automatic test_seq_reset_priority;
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    rx(1, 0); rx(2, 0); rx(3, 0); rx(7, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(0, 1, 4, 0, 0, 1, 9, 0, 0);
    checks++; if (expected_seq_o !== 4'd9 || state_o !== 2'd0 || resend_req_o !== 1'b0)
      begin failures++; $display("FAIL sr_exit got exp=%0d st=%0d req=%b want 9 0 0", expected_seq_o, state_o, resend_req_o); end
    checks++; if ({rx_accept_o, rx_dup_o, rx_gap_o, rx_low_o} !== 4'd0)
      begin failures++; $display("FAIL sr_nopulse got=%b want=0000", {rx_accept_o, rx_dup_o, rx_gap_o, rx_low_o}); end
  endtask

  task automatic test_low_dup;
    tick(0, 0, 0, 0, 0, 1, 10, 0, 0);
    rx(5, 1);
    checks++; if ({rx_accept_o, rx_dup_o, rx_gap_o, rx_low_o, err_low_o} !== 5'b01000)
      begin failures++; $display("FAIL dup got=%b want=01000", {rx_accept_o, rx_dup_o, rx_gap_o, rx_low_o, err_low_o}); end
    rx(5, 0);
    checks++; if ({rx_dup_o, rx_low_o, err_low_o} !== 3'b011 || expected_seq_o !== 4'd10)
      begin failures++; $display("FAIL low got=%b exp=%0d want=011 10", {rx_dup_o, rx_low_o, err_low_o}, expected_seq_o); end
    tick(0, 0, 0, 0, 0, 1, 3, 0, 0);
    checks++; if (rx_low_o !== 1'b1 || expected_seq_o !== 4'd10)
      begin failures++; $display("FAIL sr_back got low=%b exp=%0d want 1 10", rx_low_o, expected_seq_o); end
    tick(0, 1, 10, 0, 1, 0, 0, 0, 0);
    checks++; if (expected_seq_o !== 4'd10 || rx_accept_o !== 1'b0)
      begin failures++; $display("FAIL ignore got exp=%0d acc=%b want 10 0", expected_seq_o, rx_accept_o); end
  endtask

  task automatic test_reset_mid;
    rx(12, 0);
    checks++; if (state_o !== 2'd1 || err_low_o !== 1'b1)
      begin failures++; $display("FAIL mid_pre got st=%0d err=%b want 1 1", state_o, err_low_o); end
    tick(1, 1, 10, 0, 0, 0, 0, 1, 1);
    checks++; if ({state_o, resend_req_o, err_low_o, rx_accept_o, rx_gap_o} !== 6'd0 || expected_seq_o !== 4'd1 ||
                  outgoing_seq_o !== 4'd1 || resend_begin_o !== 4'd0 || resend_end_o !== 4'd0)
      begin failures++; $display("FAIL mid_reset got st=%0d req=%b err=%b exp=%0d out=%0d b=%0d e=%0d", state_o, resend_req_o, err_low_o, expected_seq_o, outgoing_seq_o, resend_begin_o, resend_end_o); end
  endtask

  task automatic test_wrap;
    tick(0, 0, 0, 0, 0, 1, 15, 0, 0);
    rx(15, 0);
    checks++; if (expected_seq_o !== 4'd1 || rx_accept_o !== 1'b1)
      begin failures++; $display("FAIL wrap_exp got=%0d acc=%b want 1 1", expected_seq_o, rx_accept_o); end
    for (int i = 0; i < 14; i++) tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++; if (outgoing_seq_o !== 4'd15) begin failures++; $display("FAIL wrap_out15 got=%0d want=15", outgoing_seq_o); end
    tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++; if (outgoing_seq_o !== 4'd1) begin failures++; $display("FAIL wrap_out got=%0d want=1", outgoing_seq_o); end
  endtask

  task automatic test_random;
    int got[11];
    int want[11];
    string nm[11] = '{"exp", "out", "state", "begin", "end", "req", "err", "acc", "dup", "gap", "low"};
    for (int n = 0; n < 3000; n++) begin
      int seq;
      int nsq;
      seq = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : (m_exp + int'($urandom_range(0, 2))) % 16;
      nsq = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : m_exp + 3 > 15 ? 15 : m_exp + 3;
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, seq, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, nsq,
           $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
      got  = '{int'(expected_seq_o), int'(outgoing_seq_o), int'(state_o), int'(resend_begin_o), int'(resend_end_o),
               int'(resend_req_o), int'(err_low_o), int'(rx_accept_o), int'(rx_dup_o), int'(rx_gap_o), int'(rx_low_o)};
      want = '{m_exp, m_out, m_state, m_begin, m_end, m_req, m_err, m_acc, m_dup, m_gap, m_low};
      for (int k = 0; k < 11; k++) begin
        checks++;
        if (got[k] !== want[k]) begin
          failures++;
          $display("FAIL rand_%s cycle=%0d got=%0d want=%0d", nm[k], n, got[k], want[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_gap_recovery();
    test_seq_reset_priority();
    test_low_dup();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
